// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller.
//   SEG_BLANK : active-low segment pattern with every segment dark
//   BCD_BLANK : nibble code the decoder renders as a dark digit
//   state_t   : scan sequencer states
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEAD,
        S_SHOW
    } state_t;

endpackage

// File: rtl/bcd7seg.sv
// BCD to 7-segment decoder, combinational.
//   i_bcd : BCD digit; codes 10..15 decode to a dark digit
//   o_seg : segments a..g on bits 6..0, active-low (0 = lit)
module bcd7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = 7'b0000001;
            4'd1:    o_seg = 7'b1001111;
            4'd2:    o_seg = 7'b0010010;
            4'd3:    o_seg = 7'b0000110;
            4'd4:    o_seg = 7'b1001100;
            4'd5:    o_seg = 7'b0100100;
            4'd6:    o_seg = 7'b0100000;
            4'd7:    o_seg = 7'b0001111;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0000100;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment display controller.
// Accepts a packed BCD word over valid/ready into a pending register and
// commits it to the shown word only at a frame boundary (or while idle),
// then scans one digit per DIV-cycle slot with DEAD blank cycles up front.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : scan enable; low blanks the display and parks the scanner
//   lz_blank   : enable leading-zero blanking
//   in_valid   : display word offered
//   in_ready   : a word can be accepted (no word pending)
//   in_data    : 4*DIGITS packed BCD, digit 0 in the low nibble
//   seg_o      : registered segments a..g (bits 6..0), active-low
//   an_o       : registered digit select, active-low, at most one low
//   frame_o    : registered pulse for the last cycle of the final slot
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned DEAD   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  lz_blank,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_o
);

    localparam int unsigned DW = $clog2(DIGITS);
    localparam int unsigned CW = $clog2(DIV);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DW-1:0]         r_dig;
    logic [4*DIGITS-1:0]   r_disp;
    logic [4*DIGITS-1:0]   r_pend;
    logic                  r_pend_v;
    logic [6:0]            r_seg;
    logic [DIGITS-1:0]     r_an;
    logic                  r_frame;

    logic                  w_show;
    logic                  w_bnd;
    logic                  w_commit;
    logic [3:0]            w_nib;
    logic [3:0]            w_bcd;
    logic [6:0]            w_seg;
    logic [DIGITS-1:0]     w_lz_mask;

    assign w_show   = (r_state == S_SHOW);
    assign w_bnd    = w_show && (r_cnt == CW'(DIV - 1)) && (r_dig == DW'(DIGITS - 1));
    assign w_commit = r_pend_v && (w_bnd || (r_state == S_IDLE));
    assign w_nib    = r_disp[{r_dig, 2'b00} +: 4];

    // Walk from the top digit down; a digit is blanked while every nibble
    // from it upward is zero. Digit 0 is never blanked.
    always_comb begin
        logic v_hi_zero;
        w_lz_mask = '0;
        v_hi_zero = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            v_hi_zero = v_hi_zero && (r_disp[4*(DIGITS-1-k) +: 4] == 4'h0);
            if (k != DIGITS - 1) begin
                w_lz_mask[DIGITS-1-k] = lz_blank && v_hi_zero;
            end
        end
    end

    assign w_bcd = (w_show && !w_lz_mask[r_dig]) ? w_nib : BCD_BLANK;

    bcd7seg u_dec (
        .i_bcd (w_bcd),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dig    <= '0;
            r_disp   <= {DIGITS{BCD_BLANK}};
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_seg    <= SEG_BLANK;
            r_an     <= '1;
            r_frame  <= 1'b0;
        end else begin
            // Pins follow the sequencer one cycle late.
            r_seg   <= w_seg;
            r_an    <= w_show ? ~(DIGITS'(1) << r_dig) : '1;
            r_frame <= w_bnd;

            // Commit needs a pending word, so it can never coincide with
            // an accepted transfer (in_ready is low whenever pend_v is set).
            if (w_commit) begin
                r_disp   <= r_pend;
                r_pend_v <= 1'b0;
            end else if (in_valid && !r_pend_v) begin
                r_pend   <= in_data;
                r_pend_v <= 1'b1;
            end

            if (!en) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_dig   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_DEAD;
                        r_cnt   <= '0;
                        r_dig   <= '0;
                    end
                    S_DEAD: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(DEAD - 1)) begin
                            r_state <= S_SHOW;
                        end
                    end
                    S_SHOW: begin
                        if (r_cnt == CW'(DIV - 1)) begin
                            r_state <= S_DEAD;
                            r_cnt   <= '0;
                            r_dig   <= (r_dig == DW'(DIGITS - 1)) ? '0 : r_dig + 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign in_ready = !r_pend_v;
    assign seg_o    = r_seg;
    assign an_o     = r_an;
    assign frame_o  = r_frame;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int DEAD   = 2;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        lz_blank;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_o;

    seg_scan_ctrl #(
        .DIGITS (DIGITS),
        .DIV    (DIV),
        .DEAD   (DEAD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .lz_blank (lz_blank),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .seg_o    (seg_o),
        .an_o     (an_o),
        .frame_o  (frame_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Segment glyphs, active-low a..g on bits 6..0.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'h7F;
        endcase
    endfunction

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       frame;
        logic       ready;
    } exp_t;

    exp_t sb[$];

    // Reference model: the scan position is a single "cycles since scanning
    // began" count; slot, position and digit fall out by division.
    int          m_phase = -1;
    int          m_pos;
    int          m_d;
    bit          m_lit;
    bit          m_bnd;
    logic [15:0] m_disp  = 16'hFFFF;
    logic [15:0] m_pend  = 16'h0;
    bit          m_pv    = 1'b0;
    logic [3:0]  m_nib;
    exp_t        m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = -1;
            m_disp  = 16'hFFFF;
            m_pend  = 16'h0;
            m_pv    = 1'b0;
        end else begin
            if (m_phase < 0) begin
                m_lit = 1'b0;
                m_bnd = 1'b0;
                m_d   = 0;
            end else begin
                m_pos = m_phase % DIV;
                m_d   = (m_phase / DIV) % DIGITS;
                m_lit = (m_pos >= DEAD);
                m_bnd = m_lit && (m_pos == DIV - 1) && (m_d == DIGITS - 1);
            end
            m_nib = 4'((m_disp >> (4 * m_d)) & 16'hF);
            if (lz_blank && m_d > 0 && ((m_disp >> (4 * m_d)) == 16'h0)) m_nib = 4'hF;
            m_e.seg   = m_lit ? glyph(m_nib) : 7'h7F;
            m_e.an    = m_lit ? ~(4'b0001 << m_d) : 4'hF;
            m_e.frame = m_bnd;

            if (m_pv && (m_phase < 0 || m_bnd)) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end else if (in_valid && !m_pv) begin
                m_pend = in_data;
                m_pv   = 1'b1;
            end
            m_e.ready = !m_pv;

            if (!en)              m_phase = -1;
            else if (m_phase < 0) m_phase = 0;
            else                  m_phase = m_phase + 1;

            sb.push_back(m_e);
        end
    end

    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("seg_o",    32'(seg_o),    32'(mon_e.seg));
            check("an_o",     32'(an_o),     32'(mon_e.an));
            check("frame_o",  32'(frame_o),  32'(mon_e.frame));
            check("in_ready", 32'(in_ready), 32'(mon_e.ready));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold in_valid until a transfer is observed at an edge, bounded.
    task automatic send(input logic [15:0] w);
        bit ok;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        lz_blank = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_seg",   32'(seg_o),    32'h7F);
        check("rst_an",    32'(an_o),     32'hF);
        check("rst_frame", 32'(frame_o),  32'h0);
        check("rst_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;

        // Blank scan after reset, two full frames.
        en = 1'b1;
        step(70);

        // Load while disabled, then enable.
        en = 1'b0;
        step(3);
        send(16'h1234);
        step(4);
        en = 1'b1;
        step(80);

        // Mid-frame write: held off until the boundary.
        step(13);
        send(16'h0000);
        step(70);

        // Leading-zero blanking.
        lz_blank = 1'b1;
        send(16'h0070);
        step(80);

        // Second word offered while the first is still pending.
        lz_blank = 1'b0;
        send(16'h5678);
        send(16'h9ABC);
        step(100);

        // Asynchronous reset mid-slot with a word pending.
        send(16'h4321);
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_seg",   32'(seg_o),    32'h7F);
        check("arst_an",    32'(an_o),     32'hF);
        check("arst_frame", 32'(frame_o),  32'h0);
        check("arst_ready", 32'(in_ready), 32'h1);
        step(2);
        rst_n = 1'b1;
        check("post_rst_ready", 32'(in_ready), 32'h1);
        step(70);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0)  en = ~en;
            if ($urandom_range(0, 199) == 0) lz_blank = ~lz_blank;
            in_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) in_data = 16'($urandom_range(0, 255));
            else                           in_data = 16'($urandom);
            step(1);
        end
        in_valid = 1'b0;
        step(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed controller for a common-anode multi-digit 7-segment display. It accepts a packed BCD word over a valid/ready handshake and holds it in a frame-synchronous shadow register. It scans one digit per time slot, inserting dead time between digits, and drives a single shared `bcd7seg` decoder. It sits between the NPC debug/status logic and the board's segment/anode pins.

## Interface
- `DIGITS`, 8: number of digits scanned (2..8).
- `DIV`, 50000: clock cycles per digit slot (≥ 4).
- `DEAD`, 16: blank cycles at the start of each slot (1 ≤ DEAD < DIV).
- `clk`  in  1: single clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: scan enable. Low forces a blank display.
- `lz_blank`  in  1: enables leading-zero blanking.
- `in_valid`  in  1: new display word offered.
- `in_ready`  out  1: controller can accept a word.
- `in_data`  in  4*DIGITS: digit i at bits [4i+3:4i]; digit 0 is least significant. Codes 10–15 display blank.
- `seg_o`  out  7: segments a..g on bits 6..0, active-low (0 = lit).
- `an_o`  out  DIGITS: digit select, active-low, at most one bit low.
- `frame_o`  out  1: one-cycle pulse on the last cycle of the final digit slot.

## Operation
- Registers:
  - `disp` (4*DIGITS, shown word).
  - `pend` (4*DIGITS) plus `pend_v`.
  - `cnt` (0..DIV-1).
  - `dig` (0..DIGITS-1).
  - state.
- States:
  - IDLE: outputs blank, `cnt`=0, `dig`=0.
    - `en`=1 → DEAD.
  - DEAD: `an_o` all 1s, `seg_o`=7'h7F.
    - `cnt`==DEAD-1 → SHOW.
  - SHOW: `an_o[dig]`=0; `seg_o` = decode of nibble `dig` of `disp`, or blank if blanked.
    - `cnt`==DIV-1 → DEAD, with `dig` incremented (wraps DIGITS-1→0) and `cnt`=0.
  - `en`=0 in any state → IDLE on the next edge. Re-enabling always restarts at digit 0 in DEAD.
- Handshake:
  - `in_ready` = !`pend_v`.
  - A transfer happens on `in_valid` && `in_ready` and loads `pend` and sets `pend_v`.
  - `in_data` is sampled only on a transfer.
- Frame-synchronous commit:
  - When `pend_v` and (frame boundary, i.e. SHOW with `cnt`==DIV-1 and `dig`==DIGITS-1), or when in IDLE: `disp`←`pend` and `pend_v` clears.
  - `in_ready` therefore rises the cycle after the commit.
  - No word can be accepted in the same cycle it is committed.
  - No tearing: `disp` never changes mid-frame while enabled.
- Leading-zero blanking (`lz_blank`=1):
  - Digit i>0 is blank if nibble i and all higher nibbles are 0.
  - Digit 0 is never blanked by this rule.
  - The rule is evaluated on `disp`.
- `frame_o` pulses only while `en`=1. It pulses regardless of commit.

## Timing
- Reset values:
  - `seg_o`=7'h7F, `an_o`=all 1s, `in_ready`=1, `frame_o`=0.
  - `disp`=all 4'hF (blank), `pend_v`=0.
  - state IDLE, `cnt`=0, `dig`=0.
- `seg_o`, `an_o` and `frame_o` are registered. Each reflects the state/`cnt`/`dig` of the previous cycle (1-cycle latency). The decoder output is registered before the pins.
- Slot = DIV cycles: DEAD blank + (DIV-DEAD) lit. Frame = DIGITS*DIV cycles.
- From IDLE with a pending word: the commit takes 1 cycle and `in_ready` returns high on the 2nd cycle.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). A pending word is discarded.
- `en` dropping mid-slot: the pins are blank from the 2nd edge after the drop (state + output register).

## Structure
- Shared package `seg_pkg`:
  - `SEG_BLANK`=7'h7F.
  - `BCD_BLANK`=4'hF.
  - state enum {`S_IDLE`, `S_DEAD`, `S_SHOW`}.
- One sub-module: the existing `bcd7seg` decoder, instantiated once.
  - It is fed the selected nibble, or `BCD_BLANK` when blanked.
  - Its output is registered into `seg_o`.
- The remaining logic lives in `seg_scan_ctrl`:
  - counter/FSM.
  - handshake/shadow register.
  - leading-zero mask.

## Test plan
(Bench parameters: DIGITS=4, DIV=8, DEAD=2.)
- Reset release with `en`=1 and no write:
  - Every slot shows `seg_o`=7'h7F.
  - `an_o` cycles 1110→1101→1011→0111, 6 lit cycles each, separated by 2 all-1s cycles.
  - `frame_o` pulses every 32 cycles.
- `en`=0, write 16'h1234:
  - `in_ready` drops for 1 cycle.
  - After `en`=1, digit 0 shows 7'b1001100 ('4') and digit 3 shows 7'b1001111 ('1').
- Mid-frame write of 16'h0000 while showing 16'h1234:
  - Digits keep showing 1234 until `frame_o`.
  - `in_ready` stays low until the cycle after the boundary.
  - The next frame shows 0000.
- `lz_blank`=1 with word 16'h0070:
  - Digits 3 and 2 are blank (7'h7F).
  - Digit 1 shows 7'b0001111 ('7').
  - Digit 0 shows 7'b0000001 ('0').
- `in_valid` held with a second word while `pend_v`=1:
  - No second transfer occurs until the commit.
  - The second word appears exactly one frame later.
- `rst_n` pulsed low mid-slot with a word pending:
  - Outputs go to reset values immediately.
  - After release the display is blank and `in_ready`=1.
